// File: rtl/gate_stage_pkg.sv
// Shared definitions for registered gate output stages: occupancy state
// encoding and valid/ready handshake fire helpers.
package gate_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    function automatic logic hs_fire(input logic vld, input logic rdy);
        return vld & rdy;
    endfunction

endpackage

// File: rtl/gate_skid_reg_en_reg.sv
// Enable register with asynchronous active-low reset to RESET_VAL.
// Latency: one cycle from enabled d to q; no flow control of its own.
module en_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/gate_skid_reg.sv
// Two-entry skid register behind the gate array: accepted beat is on OUT0 after one edge.
// Full throughput; IN_READY drops only when both entries are held or FLUSH is high.
module gate_skid_reg
    import gate_stage_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] IN0,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT0,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [1:0]       LEVEL
);

    stage_state_e     state_d, state_q;
    logic             out_valid_d, out_valid_q;
    logic             in_ready_d, in_ready_q;
    logic [1:0]       level_d, level_q;

    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_din;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // FLUSH is the only combinational term allowed onto IN_READY.
    assign IN_READY  = in_ready_q & ~FLUSH;
    assign OUT_VALID = out_valid_q;
    assign OUT0      = main_q;
    assign LEVEL     = level_q;

    assign in_fire  = hs_fire(IN_VALID, IN_READY);
    assign out_fire = hs_fire(out_valid_q, OUT_READY);

    always_comb begin
        state_d  = state_q;
        main_en  = 1'b0;
        skid_en  = 1'b0;
        main_din = IN0;
        if (FLUSH) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_en = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        skid_en = 1'b1;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Skid always drains into main, keeping FIFO order.
                    if (out_fire) begin
                        main_din = skid_q;
                        main_en  = 1'b1;
                        state_d  = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
        level_d     = state_d;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            level_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            level_q     <= level_d;
        end
    end

    en_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (CLK),
        .rst_n (RSTn),
        .en    (main_en),
        .d     (main_din),
        .q     (main_q)
    );

    en_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk   (CLK),
        .rst_n (RSTn),
        .en    (skid_en),
        .d     (IN0),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_gate_skid_reg.sv
// Directed bench for gate_skid_reg with WIDTH=8, RESET_VAL=0.
module tb_gate_skid_reg;

    logic       CLK;
    logic       RSTn;
    logic       FLUSH;
    logic [7:0] IN0;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] OUT0;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [1:0] LEVEL;

    int n_cmp = 0;
    int n_err = 0;

    gate_skid_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .FLUSH     (FLUSH),
        .IN0       (IN0),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT0      (OUT0),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .LEVEL     (LEVEL)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTn      = 1'b0;
        FLUSH     = 1'b0;
        IN_VALID  = 1'b1;
        IN0       = 8'hA5;
        OUT_READY = 1'b0;
        step();
        step();
        n_cmp++;
        if (OUT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold_vld: got %b want 0", OUT_VALID);
        end
        IN_VALID = 1'b0;
        RSTn     = 1'b1;
        step();
        n_cmp++;
        if (OUT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL reset_vld: got %b want 0", OUT_VALID);
        end
        n_cmp++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rdy: got %b want 1", IN_READY);
        end
        n_cmp++;
        if (LEVEL !== 2'd0) begin
            n_err++;
            $display("FAIL reset_level: got %0d want 0", LEVEL);
        end
        n_cmp++;
        if (OUT0 !== 8'h00) begin
            n_err++;
            $display("FAIL reset_out0: got %h want 00", OUT0);
        end
    endtask

    task automatic test_streaming();
        OUT_READY = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            IN0      = 8'(i);
            IN_VALID = 1'b1;
            step();
            n_cmp++;
            if ({OUT_VALID, OUT0} !== {1'b1, 8'(i)}) begin
                n_err++;
                $display("FAIL stream_out[%0d]: got vld=%b dat=%h want vld=1 dat=%h",
                         i, OUT_VALID, OUT0, 8'(i));
            end
            n_cmp++;
            if (IN_READY !== 1'b1 || LEVEL !== 2'd1) begin
                n_err++;
                $display("FAIL stream_rdy_lvl[%0d]: got rdy=%b lvl=%0d want rdy=1 lvl=1",
                         i, IN_READY, LEVEL);
            end
        end
        IN_VALID = 1'b0;
        step();
        n_cmp++;
        if (LEVEL !== 2'd0 || OUT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL stream_drain: got lvl=%0d vld=%b want lvl=0 vld=0", LEVEL, OUT_VALID);
        end
    endtask

    task automatic test_backpressure();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN0       = 8'h11;
        step();
        IN0 = 8'h22;
        step();
        n_cmp++;
        if (LEVEL !== 2'd2 || IN_READY !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full: got lvl=%0d rdy=%b want lvl=2 rdy=0", LEVEL, IN_READY);
        end
        n_cmp++;
        if (OUT0 !== 8'h11) begin
            n_err++;
            $display("FAIL bp_hold_out0: got %h want 11", OUT0);
        end
        IN0 = 8'h33;
        step();
        n_cmp++;
        if (LEVEL !== 2'd2 || OUT0 !== 8'h11 || OUT_VALID !== 1'b1) begin
            n_err++;
            $display("FAIL bp_third_held: got lvl=%0d dat=%h vld=%b want lvl=2 dat=11 vld=1",
                     LEVEL, OUT0, OUT_VALID);
        end
        OUT_READY = 1'b1;
        step();
        n_cmp++;
        if (OUT0 !== 8'h22 || LEVEL !== 2'd1) begin
            n_err++;
            $display("FAIL bp_drain_22: got dat=%h lvl=%0d want dat=22 lvl=1", OUT0, LEVEL);
        end
        step();
        n_cmp++;
        if (OUT0 !== 8'h33 || LEVEL !== 2'd1) begin
            n_err++;
            $display("FAIL bp_drain_33: got dat=%h lvl=%0d want dat=33 lvl=1", OUT0, LEVEL);
        end
        IN_VALID = 1'b0;
        step();
        n_cmp++;
        if (LEVEL !== 2'd0 || OUT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL bp_empty: got lvl=%0d vld=%b want lvl=0 vld=0", LEVEL, OUT_VALID);
        end
    endtask

    task automatic test_simultaneous();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN0       = 8'h44;
        step();
        n_cmp++;
        if (OUT0 !== 8'h44 || LEVEL !== 2'd1) begin
            n_err++;
            $display("FAIL sim_hold44: got dat=%h lvl=%0d want dat=44 lvl=1", OUT0, LEVEL);
        end
        IN0       = 8'h55;
        OUT_READY = 1'b1;
        step();
        n_cmp++;
        if (OUT0 !== 8'h55 || LEVEL !== 2'd1 || IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL sim_swap55: got dat=%h lvl=%0d rdy=%b want dat=55 lvl=1 rdy=1",
                     OUT0, LEVEL, IN_READY);
        end
        IN_VALID = 1'b0;
        step();
        n_cmp++;
        if (LEVEL !== 2'd0 || OUT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL sim_empty: got lvl=%0d vld=%b want lvl=0 vld=0", LEVEL, OUT_VALID);
        end
    endtask

    task automatic test_flush();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN0       = 8'h66;
        step();
        IN0 = 8'h77;
        step();
        n_cmp++;
        if (LEVEL !== 2'd2) begin
            n_err++;
            $display("FAIL flush_pre_full: got lvl=%0d want 2", LEVEL);
        end
        IN0   = 8'h88;
        FLUSH = 1'b1;
        #1;
        n_cmp++;
        if (IN_READY !== 1'b0) begin
            n_err++;
            $display("FAIL flush_rdy_low: got %b want 0", IN_READY);
        end
        step();
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        #1;
        n_cmp++;
        if (LEVEL !== 2'd0 || OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL flush_empty: got lvl=%0d vld=%b rdy=%b want lvl=0 vld=0 rdy=1",
                     LEVEL, OUT_VALID, IN_READY);
        end
        n_cmp++;
        if (OUT0 !== 8'h66) begin
            n_err++;
            $display("FAIL flush_data_kept: got %h want 66", OUT0);
        end
        step();
        n_cmp++;
        if (LEVEL !== 2'd0 || OUT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL flush_88_dropped: got lvl=%0d vld=%b want lvl=0 vld=0", LEVEL, OUT_VALID);
        end
    endtask

    task automatic test_async_reset();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN0       = 8'hAA;
        step();
        IN0 = 8'hBB;
        step();
        n_cmp++;
        if (LEVEL !== 2'd2 || OUT0 !== 8'hAA) begin
            n_err++;
            $display("FAIL arst_pre_full: got lvl=%0d dat=%h want lvl=2 dat=aa", LEVEL, OUT0);
        end
        #2;
        RSTn = 1'b0;
        #1;
        n_cmp++;
        if (OUT_VALID !== 1'b0 || OUT0 !== 8'h00) begin
            n_err++;
            $display("FAIL arst_immediate: got vld=%b dat=%h want vld=0 dat=00", OUT_VALID, OUT0);
        end
        n_cmp++;
        if (LEVEL !== 2'd0 || IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL arst_level_rdy: got lvl=%0d rdy=%b want lvl=0 rdy=1", LEVEL, IN_READY);
        end
        IN_VALID = 1'b0;
        step();
        RSTn     = 1'b1;
        IN_VALID = 1'b1;
        IN0      = 8'hCC;
        step();
        IN_VALID = 1'b0;
        n_cmp++;
        if (OUT0 !== 8'hCC || OUT_VALID !== 1'b1 || LEVEL !== 2'd1) begin
            n_err++;
            $display("FAIL arst_recover: got dat=%h vld=%b lvl=%0d want dat=cc vld=1 lvl=1",
                     OUT0, OUT_VALID, LEVEL);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
